// File: rtl/client_req_queue_pkg.sv
// Shared arbiter types: client handshake states and arbiter selection codes.
// Imported by the client queue, controller, arbiter and observer.
package client_req_queue_pkg;

    typedef enum logic [1:0] {
        NO_REQ,
        REQ,
        HAVE_TOKEN,
        RELEASE
    } client_state_t;

    typedef enum logic [1:0] {
        A,
        B,
        C,
        X
    } sel_t;

endpackage

// File: rtl/req_fifo.sv
// Job FIFO for one client port; DEPTH must be a power of two (pointers wrap).
// Ports: push/din write at tail, pop/dout read head (dout is the head, not registered),
//        count = occupancy, full/empty flags. Push while full and pop while empty are ignored.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int IDW   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [IDW-1:0]           din,
    output logic [IDW-1:0]           dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IDW-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/client_req_queue.sv
// Queue-driven token-ring client: buffers producer jobs and runs a four-phase
// req/ack handshake per job, holding the grant for HOLD_CYCLES cycles.
// Ports: clk, rst_n (async, active low); job_valid/job_id/job_ready producer side;
//        req/ack controller handshake; grant_active/grant_id/done grant status;
//        count FIFO occupancy. Optional CLIENT_REQ_QUEUE_ACK_TIMEOUT_EN adds the
//        sticky starve_err output, set after TIMEOUT cycles in REQ without ack.
module client_req_queue
    import client_req_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int IDW         = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    input  logic [IDW-1:0]         job_id,
    output logic                   job_ready,
    output logic                   req,
    input  logic                   ack,
    output logic                   grant_active,
    output logic [IDW-1:0]         grant_id,
    output logic                   done,
`ifdef CLIENT_REQ_QUEUE_ACK_TIMEOUT_EN
    output logic                   starve_err,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    client_state_t  state;
    logic [HW-1:0]  hold_cnt;
    logic [IDW-1:0] head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign job_ready = !full;
    assign push      = job_valid && !full;
    // Only REQ pops, and count cannot shrink while in REQ, so the FIFO is non-empty here.
    assign pop       = (state == REQ) && ack;

    req_fifo #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (job_id),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NO_REQ;
            req          <= 1'b0;
            grant_active <= 1'b0;
            grant_id     <= '0;
            done         <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                NO_REQ: begin
                    // A stray ack here is a protocol error and is ignored.
                    if (!empty) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state        <= HAVE_TOKEN;
                        grant_id     <= head;
                        grant_active <= 1'b1;
                        hold_cnt     <= HW'(HOLD_CYCLES - 1);
                    end
                end
                HAVE_TOKEN: begin
                    if (hold_cnt == '0) begin
                        state        <= RELEASE;
                        req          <= 1'b0;
                        grant_active <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // Four-phase: no new request until the controller drops ack.
                    if (!ack) begin
                        state <= NO_REQ;
                    end
                end
                default: state <= NO_REQ;
            endcase
        end
    end

`ifdef CLIENT_REQ_QUEUE_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            starve_err <= 1'b0;
        end else if (state == NO_REQ && !empty) begin
            wait_cnt <= '0;
        end else if (state == REQ && !ack && wait_cnt != TW'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt + 1'b1 == TW'(TIMEOUT)) begin
                starve_err <= 1'b1;
            end
        end
    end
`endif

endmodule
